// File: rtl/scalar_mult_engine.sv
// LSB-first double-and-add scalar multiplier that sequences an external point adder.
// Optional build macro SCALAR_MULT_CONST_TIME_EN: fixed K_WIDTH adds + K_WIDTH doublings per job.
module scalar_mult_engine #(
  parameter int DATA_WIDTH = 256,
  parameter int K_WIDTH    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] Px,
  input  logic [DATA_WIDTH-1:0] Py,
  input  logic [K_WIDTH-1:0]    k,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] Rx,
  output logic [DATA_WIDTH-1:0] Ry,
  output logic                  out_inf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  pa_valid,
  output logic [DATA_WIDTH-1:0] pa_Px,
  output logic [DATA_WIDTH-1:0] pa_Py,
  output logic [DATA_WIDTH-1:0] pa_Qx,
  output logic [DATA_WIDTH-1:0] pa_Qy,
  input  logic                  pa_done,
  input  logic [DATA_WIDTH-1:0] pa_Rx,
  input  logic [DATA_WIDTH-1:0] pa_Ry
);

  localparam int IW = $clog2(K_WIDTH + 1);
  localparam logic [IW-1:0] K_LAST = IW'(K_WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_DBL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] t_x_q, t_x_d, t_y_q, t_y_d;
  logic [DATA_WIDTH-1:0] r_x_q, r_x_d, r_y_q, r_y_d;
  logic                  r_inf_q, r_inf_d;
  logic [K_WIDTH-1:0]    k_q, k_d;   // scalar shifted right per doubling: k_q[0] is bit i
  logic [IW-1:0]         i_q, i_d;
  logic                  pa_valid_q, pa_valid_d;

`ifdef SCALAR_MULT_CONST_TIME_EN
  logic dummy_q, dummy_d;  // current ADD result is discarded
`else
  logic rest_zero;         // bits above i are all zero
  assign rest_zero = ((k_q >> 1) == '0);
`endif

  // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    t_x_d      = t_x_q;
    t_y_d      = t_y_q;
    r_x_d      = r_x_q;
    r_y_d      = r_y_q;
    r_inf_d    = r_inf_q;
    k_d        = k_q;
    i_d        = i_q;
    pa_valid_d = 1'b0;
`ifdef SCALAR_MULT_CONST_TIME_EN
    dummy_d    = dummy_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CHECK;
          t_x_d   = Px;
          t_y_d   = Py;
          k_d     = k;
          i_d     = '0;
          r_x_d   = '0;
          r_y_d   = '0;
          r_inf_d = 1'b1;
        end
      end
      S_CHECK: begin
`ifdef SCALAR_MULT_CONST_TIME_EN
        if (i_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_ADD;
          pa_valid_d = 1'b1;
          dummy_d    = !k_q[0] || r_inf_q;
          if (k_q[0] && r_inf_q) begin
            r_x_d   = t_x_q;
            r_y_d   = t_y_q;
            r_inf_d = 1'b0;
          end
        end
`else
        if (i_q == K_LAST || k_q == '0) begin
          state_d = S_DONE;
        end else if (k_q[0]) begin
          if (r_inf_q) begin
            // First set bit: R = infinity + T = T, no adder call needed.
            r_x_d   = t_x_q;
            r_y_d   = t_y_q;
            r_inf_d = 1'b0;
            if (rest_zero) begin
              state_d = S_DONE;
            end else begin
              state_d    = S_DBL;
              pa_valid_d = 1'b1;
            end
          end else begin
            state_d    = S_ADD;
            pa_valid_d = 1'b1;
          end
        end else begin
          state_d    = S_DBL;
          pa_valid_d = 1'b1;
        end
`endif
      end
      S_ADD: begin
        if (pa_done) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
          if (!dummy_q) begin
            r_x_d = pa_Rx;
            r_y_d = pa_Ry;
          end
          state_d    = S_DBL;
          pa_valid_d = 1'b1;
`else
          r_x_d = pa_Rx;
          r_y_d = pa_Ry;
          if (rest_zero) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_DBL;
            pa_valid_d = 1'b1;
          end
`endif
        end
      end
      S_DBL: begin
        if (pa_done) begin
          t_x_d   = pa_Rx;
          t_y_d   = pa_Ry;
          i_d     = i_q + IW'(1);
          k_d     = k_q >> 1;
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      pa_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      t_x_q      <= '0;
      t_y_q      <= '0;
      r_x_q      <= '0;
      r_y_q      <= '0;
      r_inf_q    <= 1'b0;
      k_q        <= '0;
      i_q        <= '0;
      pa_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_x_q      <= t_x_d;
      t_y_q      <= t_y_d;
      r_x_q      <= r_x_d;
      r_y_q      <= r_y_d;
      r_inf_q    <= r_inf_d;
      k_q        <= k_d;
      i_q        <= i_d;
      pa_valid_q <= pa_valid_d;
    end
  end

`ifdef SCALAR_MULT_CONST_TIME_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dummy_q <= 1'b0;
    else        dummy_q <= dummy_d;
  end
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Rx        = r_x_q;
  assign Ry        = r_y_q;
  assign out_inf   = r_inf_q;
  assign pa_valid  = pa_valid_q;
  // Operands come straight from T and R, which only change on pa_done, so they hold for the call.
  assign pa_Px     = t_x_q;
  assign pa_Py     = t_y_q;
  assign pa_Qx     = (state_q == S_DBL) ? t_x_q : r_x_q;
  assign pa_Qy     = (state_q == S_DBL) ? t_y_q : r_y_q;

endmodule

// File: tb/tb_scalar_mult_engine.sv
// Self-checking bench for scalar_mult_engine: the point adder is modelled as modular addition,
// so every result must equal k*P mod 2^DW in both coordinates.
module tb_scalar_mult_engine;

  localparam int DW = 16;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] Px, Py, Rx, Ry;
  logic [KW-1:0] k;
  logic          in_valid, in_ready, abort;
  logic          out_inf, out_valid, out_ready, busy;
  logic          pa_valid, pa_done;
  logic [DW-1:0] pa_Px, pa_Py, pa_Qx, pa_Qy, pa_Rx, pa_Ry;

  int vectors = 0;
  int errors  = 0;
  int pa_calls = 0;

  scalar_mult_engine #(.DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
    .clk(clk), .rst_n(rst_n), .Px(Px), .Py(Py), .k(k),
    .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
    .Rx(Rx), .Ry(Ry), .out_inf(out_inf), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy),
    .pa_valid(pa_valid), .pa_Px(pa_Px), .pa_Py(pa_Py), .pa_Qx(pa_Qx), .pa_Qy(pa_Qy),
    .pa_done(pa_done), .pa_Rx(pa_Rx), .pa_Ry(pa_Ry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Point adder: x and y add independently mod 2^DW, result returned 3 cycles after the request.
  initial begin
    int cnt;
    logic [DW-1:0] op_x, op_y;
    cnt = 0;
    op_x = '0;
    op_y = '0;
    pa_done = 1'b0;
    pa_Rx = '0;
    pa_Ry = '0;
    forever begin
      @(posedge clk);
      #1;
      pa_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          pa_done = 1'b1;
          pa_Rx = op_x;
          pa_Ry = op_y;
        end
      end
      if (pa_valid) begin
        pa_calls++;
        op_x = pa_Px + pa_Qx;
        op_y = pa_Py + pa_Qy;
        cnt = 3;
      end
    end
  end

  // Adder calls implied by the double-and-add rules, from the scalar's bit pattern alone.
  function automatic int expected_calls(input logic [KW-1:0] kk);
`ifdef SCALAR_MULT_CONST_TIME_EN
    return 2 * KW;
`else
    int ones, msb;
    ones = 0;
    msb = -1;
    for (int b = 0; b < KW; b++) begin
      if (kk[b]) begin
        ones++;
        msb = b;
      end
    end
    if (kk == '0) return 0;
    return (ones - 1) + msb;
`endif
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
  endtask

  task automatic start_job(input logic [KW-1:0] kk, input logic [DW-1:0] px, input logic [DW-1:0] py);
    wait_ready();
    pa_calls = 0;
    k = kk;
    Px = px;
    Py = py;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
  endtask

  task automatic run_job(input logic [KW-1:0] kk, input logic [DW-1:0] px,
                         input logic [DW-1:0] py, input int hold);
    int n;
    logic [DW-1:0] exp_x, exp_y, held_x;
    exp_x = DW'(32'(kk) * 32'(px));
    exp_y = DW'(32'(kk) * 32'(py));
    start_job(kk, px, py);
    n = 0;
    while (!out_valid && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_valid_wait", out_valid, 1'b1);
    if (!out_valid) return;
    held_x = Rx;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_rx", Rx, held_x);
    end
    check("rx", Rx, exp_x);
    check("ry", Ry, exp_y);
    check("out_inf", out_inf, (kk == '0));
    check("adder_calls", pa_calls, expected_calls(kk));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_back", in_ready, 1'b1);
  endtask

  task automatic wait_calls(input int target);
    int n = 0;
    while (pa_calls < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("calls_reached", (pa_calls >= target), 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    k = '0;
    Px = '0;
    Py = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pa_valid", pa_valid, 1'b0);
    check("rst_rx", Rx, '0);
    check("rst_ry", Ry, '0);
    check("rst_out_inf", out_inf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    run_job(8'h00, 16'd7, 16'd9, 0);
    run_job(8'h01, 16'd7, 16'd9, 0);
    run_job(8'h05, 16'd7, 16'd9, 0);
    run_job(8'hFF, 16'd3, 16'd5, 10);

    // Abort during the third doubling; the late pa_done must not revive the job.
    start_job(8'h80, 16'd5, 16'd6);
    wait_calls(3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_pa_valid", pa_valid, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_late_done_busy", busy, 1'b0);
    check("abort_late_done_out_valid", out_valid, 1'b0);
    run_job(8'h02, 16'd4, 16'd1, 0);

    // Reset while the first real add is outstanding.
    start_job(8'hFF, 16'd3, 16'd5);
    wait_calls(2);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_pa_valid", pa_valid, 1'b0);
    check("midrst_rx", Rx, '0);
    check("midrst_ry", Ry, '0);
    check("midrst_out_inf", out_inf, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_late_done_busy", busy, 1'b0);
    check("midrst_late_done_out_valid", out_valid, 1'b0);

    for (int j = 0; j < 24; j++) begin
      logic [KW-1:0] rk;
      rk = (j % 6 == 0) ? '0 : KW'($urandom);
      run_job(rk, DW'($urandom), DW'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
